mac_ctrl: RTL and testbench

MAC_CTRL -- requirements
Module: mac_ctrl

---
 rtl/mac_ctrl_if.sv | 45 ++++
 rtl/mac_ctrl.sv | 106 ++++++++++
 tb/tb_mac_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_ctrl_if.sv
// mac_ctrl_if: bundles the job, operand-stream, result-stream and MAC-drive signals of
// mac_ctrl into one interface.
//   slave  : the controller side (mac_ctrl itself)
//   master : the environment side (job source, operand source, result sink, MAC)
// Signals:
//   Start_SI/Len_DI           job start pulse and pair count
//   Busy_SO                   controller not idle
//   In0_DI/In1_DI             operand pair, InValid_SI/InReady_SO handshake
//   Out_DO                    job result, OutValid_SO/OutReady_SI handshake
//   MacClr_SO/MacWrEn_SO      MAC clear / write enable
//   MacIn0_DO/MacIn1_DO       MAC operands
//   MacOut_DI                 MAC registered accumulator
interface mac_ctrl_if #(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned IN_WIDTH  = 12,
    parameter int unsigned LEN_WIDTH = 8
);
    logic                 Start_SI;
    logic [LEN_WIDTH-1:0] Len_DI;
    logic                 Busy_SO;
    logic [IN_WIDTH-1:0]  In0_DI;
    logic [IN_WIDTH-1:0]  In1_DI;
    logic                 InValid_SI;
    logic                 InReady_SO;
    logic [WIDTH-1:0]     Out_DO;
    logic                 OutValid_SO;
    logic                 OutReady_SI;
    logic                 MacClr_SO;
    logic                 MacWrEn_SO;
    logic [IN_WIDTH-1:0]  MacIn0_DO;
    logic [IN_WIDTH-1:0]  MacIn1_DO;
    logic [WIDTH-1:0]     MacOut_DI;

    modport slave (
        input  Start_SI, Len_DI, In0_DI, In1_DI, InValid_SI, OutReady_SI, MacOut_DI,
        output Busy_SO, InReady_SO, Out_DO, OutValid_SO, MacClr_SO, MacWrEn_SO,
               MacIn0_DO, MacIn1_DO
    );

    modport master (
        output Start_SI, Len_DI, In0_DI, In1_DI, InValid_SI, OutReady_SI, MacOut_DI,
        input  Busy_SO, InReady_SO, Out_DO, OutValid_SO, MacClr_SO, MacWrEn_SO,
               MacIn0_DO, MacIn1_DO
    );
endinterface

// File: rtl/mac_ctrl.sv
// mac_ctrl: sequences one multiply-accumulate job on an external MAC. A job clears the MAC,
// streams Len operand pairs into it, captures the MAC output and offers it downstream.
// Ports:
//   Clk_CI  clock, rising edge
//   Rst_RI  synchronous active-high reset
//   bus     mac_ctrl_if.slave (job, operand stream, result stream, MAC drive)
module mac_ctrl #(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned IN_WIDTH  = 12,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic        Clk_CI,
    input  logic        Rst_RI,
    mac_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {StIdle, StClear, StAcc, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0]     out_q, out_d;

    logic                busy;
    logic                in_ready;
    logic                out_valid;
    logic                mac_clr;
    logic                mac_wr_en;
    logic [IN_WIDTH-1:0] mac_in0;
    logic [IN_WIDTH-1:0] mac_in1;

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_q       <= out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        out_d       = out_q;
        busy        = (state_q != StIdle);
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        mac_clr     = 1'b0;
        mac_wr_en   = 1'b0;
        mac_in0     = '0;
        mac_in1     = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.Start_SI) begin
                    remaining_d = bus.Len_DI;
                    state_d     = StClear;
                end
            end
            StClear: begin
                // Clear rides on a write strobe; operands stay zero.
                mac_clr   = 1'b1;
                mac_wr_en = 1'b1;
                state_d   = (remaining_q != '0) ? StAcc : StDrain;
            end
            StAcc: begin
                in_ready = 1'b1;
                if (bus.InValid_SI) begin
                    mac_wr_en   = 1'b1;
                    mac_in0     = bus.In0_DI;
                    mac_in1     = bus.In1_DI;
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // MAC output now reflects the last write; capture it.
                out_d   = bus.MacOut_DI;
                state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (bus.OutReady_SI) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.Busy_SO     = busy;
    assign bus.InReady_SO  = in_ready;
    assign bus.OutValid_SO = out_valid;
    assign bus.Out_DO      = out_q;
    assign bus.MacClr_SO   = mac_clr;
    assign bus.MacWrEn_SO  = mac_wr_en;
    assign bus.MacIn0_DO   = mac_in0;
    assign bus.MacIn1_DO   = mac_in1;

endmodule

// File: tb/tb_mac_ctrl.sv
// tb_mac_ctrl: self-checking bench for mac_ctrl. Drives a default-width instance through a
// table of jobs plus hand-written hold/reset sequences, and an 8-bit instance for wrap.
// External MACs are modelled behaviourally: registered accumulator, clear on write strobe.
module tb_mac_ctrl;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mac_ctrl_if #(.WIDTH(24), .IN_WIDTH(12), .LEN_WIDTH(8)) bus ();
    mac_ctrl_if #(.WIDTH(8), .IN_WIDTH(8), .LEN_WIDTH(8)) bus8 ();

    mac_ctrl #(.WIDTH(24), .IN_WIDTH(12), .LEN_WIDTH(8)) dut (
        .Clk_CI (clk),
        .Rst_RI (rst),
        .bus    (bus)
    );

    mac_ctrl #(.WIDTH(8), .IN_WIDTH(8), .LEN_WIDTH(8)) dut8 (
        .Clk_CI (clk),
        .Rst_RI (rst),
        .bus    (bus8)
    );

    // MAC models
    logic [23:0] mac_acc;
    logic [7:0]  mac_acc8;

    always_ff @(posedge clk) begin
        if (rst) begin
            mac_acc <= '0;
        end else if (bus.MacWrEn_SO) begin
            mac_acc <= bus.MacClr_SO ? 24'd0 :
                       mac_acc + ({12'd0, bus.MacIn0_DO} * {12'd0, bus.MacIn1_DO});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mac_acc8 <= '0;
        end else if (bus8.MacWrEn_SO) begin
            mac_acc8 <= bus8.MacClr_SO ? 8'd0 : mac_acc8 + (bus8.MacIn0_DO * bus8.MacIn1_DO);
        end
    end

    assign bus.MacOut_DI  = mac_acc;
    assign bus8.MacOut_DI = mac_acc8;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [7:0]       len;
        logic [3:0][11:0] a;
        logic [3:0][11:0] b;
        logic             gaps;
        logic [23:0]      exp_out;
        int               exp_lat;
    } vec_t;

    vec_t vecs[6];

    // Runs one job on the default instance with OutReady held high. Cycle 0 carries Start.
    task automatic run_job(input vec_t v, output logic [23:0] res, output int lat,
                           output int wr_n, output int clr_n, output bit rdy_seen,
                           output bit bad);
        int idx;
        idx      = 0;
        res      = '0;
        lat      = -1;
        wr_n     = 0;
        clr_n    = 0;
        rdy_seen = 1'b0;
        bad      = 1'b0;
        bus.OutReady_SI = 1'b1;
        for (int c = 0; c < 100; c++) begin
            bus.Start_SI   = (c == 0);
            bus.Len_DI     = v.len;
            bus.InValid_SI = v.gaps ? c[0] : 1'b1;
            bus.In0_DI     = (idx < 4) ? v.a[idx] : 12'd0;
            bus.In1_DI     = (idx < 4) ? v.b[idx] : 12'd0;
            #1;
            if (bus.MacClr_SO) clr_n++;
            if (bus.MacWrEn_SO && !bus.MacClr_SO) wr_n++;
            if (bus.InReady_SO) rdy_seen = 1'b1;
            if ((!bus.MacWrEn_SO || bus.MacClr_SO) &&
                (bus.MacIn0_DO != 0 || bus.MacIn1_DO != 0)) bad = 1'b1;
            if (bus.MacWrEn_SO && !bus.MacClr_SO && !(bus.InValid_SI && bus.InReady_SO))
                bad = 1'b1;
            if (bus.InValid_SI && bus.InReady_SO) begin
                if (bus.MacIn0_DO != bus.In0_DI || bus.MacIn1_DO != bus.In1_DI ||
                    !bus.MacWrEn_SO) bad = 1'b1;
                idx++;
            end
            if (bus.OutValid_SO) begin
                lat = c;
                res = bus.Out_DO;
            end
            tick();
            if (lat >= 0) break;
        end
        bus.Start_SI   = 1'b0;
        bus.InValid_SI = 1'b0;
    endtask

    initial begin
        logic [23:0] res;
        int          lat, wr_n, clr_n, n;
        bit          rdy_seen, bad;
        vec_t        v;

        vecs[0] = '{len: 8'd3, a: {12'd0, 12'd5, 12'd3, 12'd1}, b: {12'd0, 12'd6, 12'd4, 12'd2},
                    gaps: 1'b0, exp_out: 24'd44, exp_lat: 6};
        vecs[1] = '{len: 8'd0, a: '0, b: '0, gaps: 1'b0, exp_out: 24'd0, exp_lat: 3};
        vecs[2] = '{len: 8'd1, a: {12'd0, 12'd0, 12'd0, 12'd7}, b: {12'd0, 12'd0, 12'd0, 12'd7},
                    gaps: 1'b0, exp_out: 24'd49, exp_lat: 4};
        vecs[3] = '{len: 8'd4, a: {4{12'd4095}}, b: {4{12'd4095}},
                    gaps: 1'b0, exp_out: 24'd16744452, exp_lat: 7};
        vecs[4] = '{len: 8'd2, a: {12'd0, 12'd0, 12'd0, 12'd10}, b: {12'd0, 12'd0, 12'd5, 12'd20},
                    gaps: 1'b0, exp_out: 24'd200, exp_lat: 5};
        vecs[5] = '{len: 8'd4, a: {4{12'd2}}, b: {4{12'd3}},
                    gaps: 1'b1, exp_out: 24'd24, exp_lat: 11};

        rst = 1'b1;
        bus.Start_SI = 1'b0;  bus.Len_DI = '0;  bus.In0_DI = '0;  bus.In1_DI = '0;
        bus.InValid_SI = 1'b0;  bus.OutReady_SI = 1'b0;
        bus8.Start_SI = 1'b0; bus8.Len_DI = '0; bus8.In0_DI = '0; bus8.In1_DI = '0;
        bus8.InValid_SI = 1'b0; bus8.OutReady_SI = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_busy",     bus.Busy_SO,     0);
        check("reset_out",      bus.Out_DO,      0);
        check("reset_outvalid", bus.OutValid_SO, 0);
        check("reset_inready",  bus.InReady_SO,  0);
        check("reset_macclr",   bus.MacClr_SO,   0);
        check("reset_macwren",  bus.MacWrEn_SO,  0);

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            run_job(v, res, lat, wr_n, clr_n, rdy_seen, bad);
            #1;
            check($sformatf("v%0d_out", i),      res,      v.exp_out);
            check($sformatf("v%0d_latency", i),  lat,      v.exp_lat);
            check($sformatf("v%0d_wr_pulses", i), wr_n,    v.len);
            check($sformatf("v%0d_clr_pulses", i), clr_n,  1);
            check($sformatf("v%0d_inready", i),  rdy_seen, (v.len != 0));
            check($sformatf("v%0d_mac_drive", i), bad,     0);
            check($sformatf("v%0d_idle_after", i), bus.Busy_SO, 0);
        end

        // Result held through a stalled DONE; Start is ignored there and in the handshake cycle.
        bus.OutReady_SI = 1'b0;
        bus.Start_SI = 1'b1; bus.Len_DI = 8'd1; bus.InValid_SI = 1'b1;
        bus.In0_DI = 12'd7;  bus.In1_DI = 12'd7;
        tick();
        bus.Start_SI = 1'b0;
        n = 0;
        while (!bus.OutValid_SO && n < 20) begin
            tick();
            n++;
        end
        bus.InValid_SI = 1'b0;
        check("hold_reached_done", bus.OutValid_SO, 1);
        for (int k = 0; k < 5; k++) begin
            bus.Start_SI = (k == 2);
            bus.Len_DI   = 8'd3;
            #1;
            check($sformatf("hold%0d_outvalid", k), bus.OutValid_SO, 1);
            check($sformatf("hold%0d_out", k),      bus.Out_DO,      49);
            tick();
        end
        bus.OutReady_SI = 1'b1;
        bus.Start_SI    = 1'b1;
        #1;
        check("handshake_outvalid", bus.OutValid_SO, 1);
        tick();
        bus.Start_SI    = 1'b0;
        bus.OutReady_SI = 1'b0;
        #1;
        check("idle_after_handshake", bus.Busy_SO, 0);
        tick();
        check("start_not_latched", bus.Busy_SO, 0);

        // Reset in the middle of a 5-pair job after two transfers.
        bus.OutReady_SI = 1'b1;
        bus.Start_SI = 1'b1; bus.Len_DI = 8'd5; bus.InValid_SI = 1'b1;
        bus.In0_DI = 12'd1;  bus.In1_DI = 12'd1;
        tick();
        bus.Start_SI = 1'b0;
        tick();
        tick();
        tick();
        check("midjob_busy", bus.Busy_SO, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.InValid_SI = 1'b0;
        #1;
        check("rst_busy",     bus.Busy_SO,     0);
        check("rst_inready",  bus.InReady_SO,  0);
        check("rst_outvalid", bus.OutValid_SO, 0);
        check("rst_out",      bus.Out_DO,      0);
        check("rst_mac_ctl",  {bus.MacClr_SO, bus.MacWrEn_SO}, 0);
        check("rst_mac_in",   {bus.MacIn0_DO, bus.MacIn1_DO},  0);
        // Start in the first cycle after reset must be accepted.
        v = vecs[2];
        run_job(v, res, lat, wr_n, clr_n, rdy_seen, bad);
        check("post_rst_out",     res, 49);
        check("post_rst_latency", lat, 4);
        check("post_rst_wr",      wr_n, 1);

        // 8-bit instance: 255*255 + 1*2 wraps to 3.
        bus8.OutReady_SI = 1'b1;
        bus8.Start_SI = 1'b1; bus8.Len_DI = 8'd2; bus8.InValid_SI = 1'b1;
        bus8.In0_DI = 8'd255; bus8.In1_DI = 8'd255;
        tick();
        bus8.Start_SI = 1'b0;
        tick();
        tick();
        bus8.In0_DI = 8'd1; bus8.In1_DI = 8'd2;
        tick();
        bus8.InValid_SI = 1'b0;
        n = 4;
        while (!bus8.OutValid_SO && n < 30) begin
            tick();
            n++;
        end
        check("w8_latency", n, 5);
        check("w8_out",     bus8.Out_DO, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
